// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU result path.
// The packed entry layout is what the result FIFO stores.
package fpu_pkg;

    typedef struct packed {
        logic [31:0] result;
        logic        error;
        logic        overflow;
        logic [1:0]  op;
    } fpu_result_t;

    localparam logic [1:0]  OP_ADD  = 2'b00;
    localparam logic [1:0]  OP_SUB  = 2'b01;
    localparam logic [1:0]  OP_MUL  = 2'b10;
    localparam logic [1:0]  OP_DIV  = 2'b11;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    // Single-precision NaN: all-ones exponent with a non-zero fraction.
    function automatic logic is_nan(input logic [31:0] word);
        return (word[30:23] == 8'hFF) && (word[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word.
// The head register holds its last value once the FIFO drains.
module fpu_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic [AW-1:0]    rd_ptr_inc_s;
    logic             push_s;
    logic             pop_s;

    assign wr_ready     = (level_r != FULL_LVL);
    assign rd_valid     = (level_r != '0);
    assign push_s       = wr_valid & wr_ready;
    assign pop_s        = rd_valid & rd_ready;
    assign rd_ptr_inc_s = rd_ptr_r + AW'(1);
    assign rd_data      = head_r;
    assign level        = level_r;

    // Next head word: a push into an empty queue or behind a lone departing entry goes straight to the head.
    always_comb begin
        head_nxt_s = head_r;
        if (push_s && (level_r == '0)) begin
            head_nxt_s = wr_data;
        end else if (pop_s && (level_r > ONE_LVL)) begin
            head_nxt_s = mem_r[rd_ptr_inc_s];
        end else if (pop_s && push_s) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage array; data only, no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            head_r   <= '0;
        end else begin
            head_r <= head_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + ONE_LVL;
                2'b01:   level_r <= level_r - ONE_LVL;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/fpu_result_queue.sv
// Result buffer behind the FPU arithmetic units: FIFO of tagged results
// plus sticky exception flags and a saturating error counter.
module fpu_result_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic                     in_error,
    input  logic                     in_overflow,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_error,
    output logic                     out_overflow,
    output logic [1:0]               out_op,
    output logic                     out_is_nan,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     flag_error,
    output logic                     flag_overflow,
    input  logic                     flag_clear,
    output logic [CNT_W-1:0]         err_count
);

    localparam int FW = $bits(fpu_result_t);

    fpu_result_t      in_ent_s;
    fpu_result_t      out_ent_s;
    logic [FW-1:0]    out_bits_s;
    logic             push_s;
    logic             flagged_s;
    logic             flag_error_r;
    logic             flag_overflow_r;
    logic [CNT_W-1:0] err_count_r;

    assign in_ent_s = '{result: in_result, error: in_error, overflow: in_overflow, op: in_op};

    fpu_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  (in_ent_s),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (out_bits_s),
        .level    (level)
    );

    assign out_ent_s    = fpu_result_t'(out_bits_s);
    assign out_result   = out_ent_s.result;
    assign out_error    = out_ent_s.error;
    assign out_overflow = out_ent_s.overflow;
    assign out_op       = out_ent_s.op;
    assign out_is_nan   = is_nan(out_ent_s.result);

    assign push_s    = in_valid & in_ready;
    assign flagged_s = in_error | in_overflow;

    // Sticky flags and error counter; a flagged push outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_error_r    <= 1'b0;
            flag_overflow_r <= 1'b0;
            err_count_r     <= '0;
        end else if (push_s) begin
            flag_error_r    <= (flag_error_r & ~flag_clear) | in_error;
            flag_overflow_r <= (flag_overflow_r & ~flag_clear) | in_overflow;
            if (flag_clear) begin
                err_count_r <= flagged_s ? CNT_W'(1) : '0;
            end else if (flagged_s && (err_count_r != {CNT_W{1'b1}})) begin
                err_count_r <= err_count_r + CNT_W'(1);
            end else begin
                err_count_r <= err_count_r;
            end
        end else if (flag_clear) begin
            flag_error_r    <= 1'b0;
            flag_overflow_r <= 1'b0;
            err_count_r     <= '0;
        end else begin
            flag_error_r    <= flag_error_r;
            flag_overflow_r <= flag_overflow_r;
            err_count_r     <= err_count_r;
        end
    end

    assign flag_error    = flag_error_r;
    assign flag_overflow = flag_overflow_r;
    assign err_count     = err_count_r;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Scoreboard bench for fpu_result_queue: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_fpu_result_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_error, in_overflow;
    logic [31:0] in_result;
    logic [1:0]  in_op;
    logic        out_valid, out_ready, out_error, out_overflow, out_is_nan;
    logic [31:0] out_result;
    logic [1:0]  out_op;
    logic [2:0]  level;
    logic        flag_error, flag_overflow, flag_clear;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;

    fpu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_error(in_error), .in_overflow(in_overflow), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_error(out_error), .out_overflow(out_overflow), .out_op(out_op),
        .out_is_nan(out_is_nan), .level(level), .flag_error(flag_error),
        .flag_overflow(flag_overflow), .flag_clear(flag_clear), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    fpu_result_t q[$];
    fpu_result_t last_head = '0;
    logic        m_fe = 1'b0, m_fo = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare current DUT state to the model, then advance the model for the coming edge
    always @(negedge clk) begin
        fpu_result_t head;
        fpu_result_t ent;
        bit do_push, do_pop;
        head = (q.size() > 0) ? q[0] : last_head;
        chk("level", 64'(level), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("out_result", 64'(out_result), 64'(head.result));
        chk("out_flags", 64'({out_error, out_overflow, out_op}),
            64'({head.error, head.overflow, head.op}));
        chk("out_is_nan", 64'(out_is_nan),
            64'((head.result[30:23] == 8'hFF) && (head.result[22:0] != 23'd0)));
        chk("flag_error", 64'(flag_error), 64'(m_fe));
        chk("flag_overflow", 64'(flag_overflow), 64'(m_fo));
        chk("err_count", 64'(err_count), 64'(m_cnt));
        last_head = head;

        if (!rst_n) begin
            q.delete();
            last_head = '0;
            m_fe = 1'b0; m_fo = 1'b0; m_cnt = 0;
        end else begin
            do_pop  = (q.size() > 0) && out_ready;
            do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                ent.result = in_result; ent.error = in_error;
                ent.overflow = in_overflow; ent.op = in_op;
                q.push_back(ent);
                if (flag_clear) begin
                    m_fe = in_error; m_fo = in_overflow;
                    m_cnt = (in_error || in_overflow) ? 1 : 0;
                end else begin
                    m_fe = m_fe | in_error; m_fo = m_fo | in_overflow;
                    if ((in_error || in_overflow) && m_cnt < 255) m_cnt++;
                end
            end else if (flag_clear) begin
                m_fe = 1'b0; m_fo = 1'b0; m_cnt = 0;
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] r, input logic e, input logic o,
                        input logic [1:0] op, input logic ordy, input logic clr, input logic rn);
        in_valid = v; in_result = r; in_error = e; in_overflow = o; in_op = op;
        out_ready = ordy; flag_clear = clr; rst_n = rn;
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] r;
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        // Single push, held at head
        step(1'b1, 32'h3FC0_0000, 1'b0, 1'b0, OP_DIV, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        // Fill to full, then a fifth offer that must be dropped
        step(1'b1, 32'h4000_0000, 1'b0, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h4040_0000, 1'b0, 1'b0, OP_SUB, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h4080_0000, 1'b0, 1'b0, OP_MUL, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        // NaN with error, then a lone clear
        step(1'b1, QNAN, 1'b1, 1'b0, OP_DIV, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        // Clear racing a flagged push
        step(1'b1, POS_INF, 1'b0, 1'b1, OP_MUL, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        // Mid-stream reset at level 2, then a fresh push
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0, OP_SUB, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        // Counter saturation
        for (int i = 0; i < 270; i++)
            step(1'b1, 32'($urandom), 1'($urandom), 1'b1, 2'($urandom), 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r[30:23] = 8'hFF;
            step(1'($urandom_range(0, 2) != 0), r, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), 2'($urandom), 1'($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
        end
        idle(1'b1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
